// File: rtl/lsu_uart_tx.sv
// Memory-mapped UART transmitter for the load/store unit: a small byte FIFO
// feeding an 8N1 serializer whose bit period is set by a runtime divisor.
module lsu_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_4000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // Register window decode
    // ---------------------------------------------------------------
    logic       sel;
    logic [1:0] offset;
    logic       push_req;
    logic       ovf_clr;
    logic       div_wr;

    assign sel      = (i_lsu_addr[31:4] == BASE_ADDR[31:4]);
    assign offset   = i_lsu_addr[3:2];
    assign push_req = i_lsu_wren && sel && (offset == 2'd0);
    assign ovf_clr  = i_lsu_wren && sel && (offset == 2'd1) && i_st_data[3];
    assign div_wr   = i_lsu_wren && sel && (offset == 2'd2);

    logic unused_bits;
    assign unused_bits = ^{i_lsu_addr[1:0], i_st_data[31:16]};

    // ---------------------------------------------------------------
    // Transmit FIFO
    // ---------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_head;
    logic          pop;
    logic          push_acc;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_FULL);
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_acc   = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_acc) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push_acc, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push_acc) begin
            fifo_mem[wr_ptr_reg] <= i_st_data[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // ---------------------------------------------------------------
    // Control registers: sticky overflow and bit-period divisor
    // ---------------------------------------------------------------
    logic        ovf_reg;
    logic [15:0] div_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ovf_reg <= 1'b0;
            div_reg <= DEFAULT_DIV;
        end else begin
            if (push_req && fifo_full && !pop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
            if (div_wr) begin
                div_reg <= (i_st_data[15:0] < 16'd2) ? 16'd2 : i_st_data[15:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Serializer FSM
    // ---------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] frame_div_reg, frame_div_next;
    logic        tx_reg, tx_next;
    logic        irq_reg, irq_next;
    logic        cnt_done;
    logic        busy;

    assign cnt_done = (cnt_reg == 16'd0);
    assign busy     = (state_reg != IDLE);

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_idx_next   = bit_idx_reg;
        cnt_next       = cnt_reg;
        frame_div_next = frame_div_reg;
        tx_next        = tx_reg;
        pop            = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    // Divisor is captured here so mid-frame writes wait for the next frame.
                    pop            = 1'b1;
                    shift_next     = fifo_head;
                    frame_div_next = div_reg;
                    cnt_next       = div_reg - 16'd1;
                    tx_next        = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                if (cnt_done) begin
                    tx_next      = shift_reg[0];
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = 3'd0;
                    cnt_next     = frame_div_reg - 16'd1;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    cnt_next = frame_div_reg - 16'd1;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (cnt_done) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop            = 1'b1;
                        shift_next     = fifo_head;
                        frame_div_next = div_reg;
                        cnt_next       = div_reg - 16'd1;
                        tx_next        = 1'b0;
                        state_next     = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        irq_next = (state_next == IDLE) && (count_next == '0);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            shift_reg     <= 8'd0;
            bit_idx_reg   <= 3'd0;
            cnt_reg       <= 16'd0;
            frame_div_reg <= DEFAULT_DIV;
            tx_reg        <= 1'b1;
            irq_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            bit_idx_reg   <= bit_idx_next;
            cnt_reg       <= cnt_next;
            frame_div_reg <= frame_div_next;
            tx_reg        <= tx_next;
            irq_reg       <= irq_next;
        end
    end

    assign o_tx  = tx_reg;
    assign o_irq = irq_reg;

    // ---------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------
    always_comb begin
        o_ld_data = 32'd0;
        if (sel) begin
            case (offset)
                2'd1:    o_ld_data = {28'd0, ovf_reg, fifo_empty, fifo_full, busy};
                2'd2:    o_ld_data = {16'd0, div_reg};
                default: o_ld_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_uart_tx.sv
// Bench for lsu_uart_tx: directed scenarios plus random bus traffic, every
// cycle compared against a frame-timeline model of the serial line.
module tb_lsu_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_4000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] st_data = 32'd0;
    logic [31:0] ld_data;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    lsu_uart_tx dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_lsu_addr (addr),
        .i_lsu_wren (wren),
        .i_st_data  (st_data),
        .o_ld_data  (ld_data),
        .o_tx       (tx),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: queue of waiting bytes plus the frame currently on the line,
    // described by its byte, its divisor and the cycles elapsed since it began.
    logic [7:0] q[$];
    bit         m_active;
    logic [7:0] m_byte;
    int         m_div;
    int         m_pos;
    bit         m_ovf;
    int         m_cfg_div;

    function automatic void model_reset();
        q.delete();
        m_active  = 0;
        m_byte    = 8'd0;
        m_div     = 434;
        m_pos     = 0;
        m_ovf     = 0;
        m_cfg_div = 434;
    endfunction

    function automatic void model_edge(input logic [31:0] a, input logic w, input logic [31:0] d);
        if (m_active) begin
            m_pos++;
            if (m_pos == 10 * m_div) m_active = 0;
        end
        if (!m_active && q.size() > 0) begin
            m_byte   = q.pop_front();
            m_div    = m_cfg_div;
            m_pos    = 0;
            m_active = 1;
        end
        if (w && a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: if (q.size() < DEPTH) q.push_back(d[7:0]); else m_ovf = 1;
                2'd1: if (d[3]) m_ovf = 0;
                2'd2: m_cfg_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
                default: ;
            endcase
        end
    endfunction

    function automatic logic exp_tx();
        int bp;
        if (!m_active) return 1'b1;
        bp = m_pos / m_div;
        if (bp == 0) return 1'b0;
        if (bp >= 9) return 1'b1;
        return m_byte[bp-1];
    endfunction

    function automatic logic [31:0] exp_ld(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd1: return {28'd0, m_ovf, (q.size() == 0), (q.size() == DEPTH), m_active};
            2'd2: return m_cfg_div;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr    = a;
        wren    = w;
        st_data = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(a, w, d);
        #1;
        check("tx", {31'd0, tx}, {31'd0, exp_tx()});
        check("irq", {31'd0, irq}, {31'd0, (!m_active && q.size() == 0)});
        check("ld", ld_data, exp_ld(a));
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) step(a, 1'b0, 32'd0);
    endtask

    initial begin
        model_reset();
        addr = BASE + 32'h4;
        step(BASE + 32'h4, 1'b0, 32'd0);
        step(BASE + 32'h8, 1'b0, 32'd0);
        rst = 1'b0;
        idle(2, BASE + 32'h4);
        idle(2, BASE + 32'h8);

        // Single frame at div 4
        step(BASE + 32'h8, 1'b1, 32'd4);
        step(BASE, 1'b1, 32'h55);
        idle(45, BASE + 32'h4);
        $display("frame 0x55 done, irq=%0b", irq);

        // Back-to-back burst with overflow and clear
        step(BASE, 1'b1, 32'hA1);
        step(BASE, 1'b1, 32'hB2);
        step(BASE, 1'b1, 32'hC3);
        step(BASE, 1'b1, 32'hD4);
        step(BASE, 1'b1, 32'hE5);
        idle(1, BASE + 32'h4);
        step(BASE, 1'b1, 32'hF6);
        idle(2, BASE + 32'h4);
        step(BASE + 32'h4, 1'b1, 32'h8);
        idle(210, BASE + 32'h4);
        $display("burst A1..E5 done, status=%h", ld_data);

        // Divisor change mid-frame, then saturation
        step(BASE, 1'b1, 32'h3C);
        step(BASE, 1'b1, 32'h96);
        idle(14, BASE + 32'h4);
        step(BASE + 32'h8, 1'b1, 32'd8);
        idle(130, BASE + 32'h8);
        step(BASE + 32'h8, 1'b1, 32'd1);
        idle(2, BASE + 32'h8);
        step(BASE + 32'h8, 1'b1, 32'd4);
        $display("divisor change done, div=%0d", ld_data);

        // Out-of-window and reserved accesses
        step(BASE + 32'h10, 1'b1, 32'h77);
        step(32'h1000_3FFC, 1'b1, 32'h77);
        step(BASE + 32'hC, 1'b1, 32'hFFFF_FFFF);
        idle(2, 32'h1000_3FFC);
        idle(2, BASE + 32'h4);
        $display("window decode done");

        // Asynchronous reset mid-frame with bytes queued
        step(BASE, 1'b1, 32'h5A);
        step(BASE, 1'b1, 32'h11);
        step(BASE, 1'b1, 32'h22);
        idle(12, BASE + 32'h4);
        addr = BASE + 32'h4;
        wren = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_status", ld_data, 32'h0000_0004);
        check("rst_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        idle(2, BASE + 32'h8);
        rst = 1'b0;
        idle(20, BASE + 32'h4);
        step(BASE + 32'h8, 1'b1, 32'd3);
        $display("async reset done, tx=%0b", tx);

        // Random bus traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25)
                step(BASE, 1'b1, $urandom);
            else if (r < 28)
                step(BASE + 32'h8, 1'b1, {$urandom_range(0, 1) == 0 ? 16'hABCD : 16'h0, 16'($urandom_range(0, 6))});
            else if (r < 31)
                step(BASE + 32'h4, 1'b1, $urandom);
            else if (r < 34)
                step(($urandom_range(0, 1) == 0) ? BASE + 32'h10 : 32'h1000_3FFC, 1'b1, $urandom);
            else if (r < 36)
                step(BASE + 32'hC, 1'b1, $urandom);
            else
                step(BASE + {28'd0, 2'($urandom_range(0, 3)), 2'b00}, 1'b0, 32'd0);
        end
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
